inst_memory_loadable: RTL and testbench
=======================================

Name: inst_memory_loadable

Overview:
- Parametrised, clocked successor to the processor's instruction memory.
- Provides a registered dual-word fetch port: instruction word plus following word, for two-word instructions carrying an immediate.
- Adds a handshaked streaming loader with start/busy/done control, replacing the raw level-sensitive write port.
- Sits between the program loader (testbench or boot logic) and the fetch stage.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 20, word-address width; depth = 2**ADDR_W words.
- CNT_W, 20, width of the load word count.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_Address  in  32  fetch word address; only [ADDR_W-1:0] used.
- Fetch_En  in  1  request fetch at PC_Address.
- Instruction  out  DATA_W  word at PC.
- Instruction_Next  out  DATA_W  word at PC+1, modulo depth.
- Fetch_Valid  out  1  Instruction and Instruction_Next valid this cycle.
- Load_Start  in  1  one-cycle pulse that begins a load.
- Load_Base  in  32  first write word address; [ADDR_W-1:0] used.
- Load_Count  in  CNT_W  number of words to load.
- Load_Data  in  DATA_W  stream word.
- Load_Valid  in  1  Load_Data valid.
- Load_Ready  out  1  loader accepts a word this cycle.
- Load_Busy  out  1  load in progress.
- Load_Done  out  1  one-cycle pulse after the last word is written.

Behaviour:
- Reset: Instruction=0, Instruction_Next=0, Fetch_Valid=0, Load_Ready=0, Load_Busy=0, Load_Done=0. FSM goes to IDLE. Memory contents are not cleared.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - Load_Start with Load_Count != 0 latches the base into wr_ptr and the count into remaining, then moves to LOAD.
  - Load_Start with Load_Count == 0 goes directly to DONE; no writes occur.
- LOAD:
  - Load_Ready=1 and Load_Busy=1.
  - A word transfers when Load_Valid && Load_Ready: write mem[wr_ptr], then wr_ptr+1 (wraps modulo 2**ADDR_W) and remaining-1.
  - When the transfer with remaining==1 occurs, move to DONE.
  - Load_Valid low is a stall: no write, no state change.
  - Load_Start while in LOAD is ignored.
- DONE: Load_Done=1 for exactly one cycle, Load_Busy=0, then return to IDLE.
- Fetch:
  - One-cycle latency. If Fetch_En is high at edge N and the FSM is not in LOAD, then after edge N: Instruction=mem[PC], Instruction_Next=mem[(PC+1) mod depth], Fetch_Valid=1.
  - If Fetch_En is low, outputs hold their previous values and Fetch_Valid=0.
  - If the FSM is in LOAD, Fetch_Valid=0 and the data outputs hold.
- Read/write collision: cannot occur, because fetch is blocked during LOAD. In DONE, a read sees all loaded data (write-before-read across the edge).
- Reset during LOAD aborts the load. Words already written stay in memory, remaining count is discarded, and Load_Done is not pulsed.
- Address bits above ADDR_W are ignored on both ports.

Optional Feature:
- Macro: LOAD_CHECKSUM_EN.
- When defined:
  - Adds output Load_Checksum (DATA_W).
  - Cleared to 0 on reset and on each accepted Load_Start.
  - Accumulates the sum of every written word, modulo 2**DATA_W.
  - Stable from the DONE cycle onward until the next Load_Start.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Decomposition:
- Package inst_mem_pkg:
  - FSM state enum (IDLE, LOAD, DONE).
  - Default width constants DATA_W_DEF=16, ADDR_W_DEF=20.
- Sub-module inst_mem_loader_fsm:
  - Owns the state, wr_ptr, remaining, handshake and optional checksum.
  - Outputs write enable, write address and data to the top level.
  - The top level holds the storage array and the registered fetch path.

Test Plan:
- Reset then idle: rst high for 2 cycles → all outputs 0 and Load_Busy=0; Fetch_Valid=0 with Fetch_En low.
- Basic load and fetch: Load_Start, base 0x10, count 3; stream 0x1111, 0x2222, 0x3333 → Load_Done pulses exactly once, one cycle after the 3rd transfer. Then fetch PC=0x11 → next cycle Instruction=0x2222, Instruction_Next=0x3333, Fetch_Valid=1.
- Stalled stream and blocked fetch: Load_Valid toggled 1,0,0,1 with count 2 → exactly 2 writes and Load_Busy stays high across the gaps. Fetch_En held high throughout → Fetch_Valid=0 while in LOAD.
- Address wrap: base 0xFFFFF, count 2, data 0xAAAA, 0xBBBB → mem[0xFFFFF]=0xAAAA and mem[0]=0xBBBB. Fetch PC=0xFFFFF → Instruction_Next=0xBBBB.
- Zero count and reset abort:
  - count 0 → Load_Done one cycle after Load_Start, with no writes.
  - Reset asserted after 1 of 4 words → FSM returns to IDLE, no Load_Done, and the first word persists.
- Checksum (LOAD_CHECKSUM_EN defined): load 0xFFFF, 0x0002 → Load_Checksum=0x0001.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// rtl/inst_mem_pkg.sv - shared loader state encoding and default widths for the loadable instruction memory.
package inst_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_e;

endpackage

// File: rtl/inst_mem_loader_fsm.sv
// rtl/inst_mem_loader_fsm.sv - handshaked streaming loader producing memory write strobes.
// Optional LOAD_CHECKSUM_EN adds a running modulo-2**DATA_W sum of written words.
module inst_mem_loader_fsm
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic [CNT_W-1:0]  load_count_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              in_load_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
`ifdef LOAD_CHECKSUM_EN
 ,output logic [DATA_W-1:0] checksum_o
`endif
);

  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    remaining_d = remaining_q;
`ifdef LOAD_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    we_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_start_i) begin
`ifdef LOAD_CHECKSUM_EN
          csum_d = '0;
`endif
          if (load_count_i != '0) begin
            wr_ptr_d    = load_base_i;
            remaining_d = load_count_i;
            state_d     = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        // Ready is constant in LOAD, so a transfer is just Load_Valid.
        if (load_valid_i) begin
          we_o        = 1'b1;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
`ifdef LOAD_CHECKSUM_EN
          csum_d      = csum_q + load_data_i;
`endif
          if (remaining_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      remaining_q <= '0;
`ifdef LOAD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      remaining_q <= remaining_d;
`ifdef LOAD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_load_o    = (state_q == LOAD);
  assign load_ready_o = in_load_o;
  assign load_busy_o  = in_load_o;
  assign load_done_o  = (state_q == DONE);
  assign waddr_o      = wr_ptr_q;
  assign wdata_o      = load_data_i;
`ifdef LOAD_CHECKSUM_EN
  assign checksum_o   = csum_q;
`endif

endmodule

// File: rtl/inst_memory_loadable.sv
// rtl/inst_memory_loadable.sv - instruction memory with registered dual-word fetch and streaming loader.
// Optional LOAD_CHECKSUM_EN exposes Load_Checksum.
module inst_memory_loadable
  import inst_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_Address,
  input  logic              Fetch_En,
  output logic [DATA_W-1:0] Instruction,
  output logic [DATA_W-1:0] Instruction_Next,
  output logic              Fetch_Valid,
  input  logic              Load_Start,
  input  logic [31:0]       Load_Base,
  input  logic [CNT_W-1:0]  Load_Count,
  input  logic [DATA_W-1:0] Load_Data,
  input  logic              Load_Valid,
  output logic              Load_Ready,
  output logic              Load_Busy,
  output logic              Load_Done
`ifdef LOAD_CHECKSUM_EN
 ,output logic [DATA_W-1:0] Load_Checksum
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              in_load;
  logic [ADDR_W-1:0] pc, pc_next;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] instr_next_q, instr_next_d;
  logic              fetch_valid_q, fetch_valid_d;

  inst_mem_loader_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_loader (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (Load_Start),
    .load_base_i  (Load_Base[ADDR_W-1:0]),
    .load_count_i (Load_Count),
    .load_data_i  (Load_Data),
    .load_valid_i (Load_Valid),
    .load_ready_o (Load_Ready),
    .load_busy_o  (Load_Busy),
    .load_done_o  (Load_Done),
    .in_load_o    (in_load),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata)
`ifdef LOAD_CHECKSUM_EN
   ,.checksum_o   (Load_Checksum)
`endif
  );

  assign pc               = PC_Address[ADDR_W-1:0];
  assign pc_next          = pc + ADDR_W'(1);
  assign unused_addr_bits = ^{PC_Address[31:ADDR_W], Load_Base[31:ADDR_W]};

  // Storage is never reset; loaded programs survive a reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_comb begin
    instr_d       = instr_q;
    instr_next_d  = instr_next_q;
    fetch_valid_d = 1'b0;
    if (Fetch_En && !in_load) begin
      instr_d       = mem_q[pc];
      instr_next_d  = mem_q[pc_next];
      fetch_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q       <= '0;
      instr_next_q  <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      instr_q       <= instr_d;
      instr_next_q  <= instr_next_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign Instruction      = instr_q;
  assign Instruction_Next = instr_next_q;
  assign Fetch_Valid      = fetch_valid_q;

endmodule

// File: tb/tb_inst_memory_loadable.sv
// tb/tb_inst_memory_loadable.sv - self-checking bench for inst_memory_loadable (define LOAD_CHECKSUM_EN to cover the checksum).
module tb_inst_memory_loadable;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 20;
  localparam logic [31:0] AMASK = 32'h000F_FFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       PC_Address = '0;
  logic              Fetch_En = 1'b0;
  logic [DATA_W-1:0] Instruction, Instruction_Next;
  logic              Fetch_Valid;
  logic              Load_Start = 1'b0;
  logic [31:0]       Load_Base = '0;
  logic [CNT_W-1:0]  Load_Count = '0;
  logic [DATA_W-1:0] Load_Data = '0;
  logic              Load_Valid = 1'b0;
  logic              Load_Ready, Load_Busy, Load_Done;
`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] Load_Checksum;
`endif

  inst_memory_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .PC_Address       (PC_Address),
    .Fetch_En         (Fetch_En),
    .Instruction      (Instruction),
    .Instruction_Next (Instruction_Next),
    .Fetch_Valid      (Fetch_Valid),
    .Load_Start       (Load_Start),
    .Load_Base        (Load_Base),
    .Load_Count       (Load_Count),
    .Load_Data        (Load_Data),
    .Load_Valid       (Load_Valid),
    .Load_Ready       (Load_Ready),
    .Load_Busy        (Load_Busy),
    .Load_Done        (Load_Done)
`ifdef LOAD_CHECKSUM_EN
   ,.Load_Checksum    (Load_Checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: sparse word store plus the expected running sum.
  logic [DATA_W-1:0] ref_mem [int];
  int                written[$];
  logic [DATA_W-1:0] ref_csum;
  logic [DATA_W-1:0] wq[$];
  int                gq[$];

  typedef struct {
    logic              en;
    logic [31:0]       pc;
    logic              valid;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] nxt;
  } fvec_t;
  fvec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_write(input logic [31:0] addr, input logic [DATA_W-1:0] d);
    int a;
    a = int'(addr & AMASK);
    if (!ref_mem.exists(a)) written.push_back(a);
    ref_mem[a] = d;
  endfunction

  // Streams wq; gq gives stall cycles before each word (random 0..3 when empty).
  task automatic do_load(input logic [31:0] base, input bit fetch_on);
    int cnt;
    int gaps;
    cnt = wq.size();
    Load_Base  = base;
    Load_Count = CNT_W'(cnt);
    Load_Start = 1'b1;
    Fetch_En   = fetch_on;
    step();
    Load_Start = 1'b0;
    ref_csum   = '0;
    if (cnt == 0) begin
      check("zero_done", Load_Done, 1);
      check("zero_busy", Load_Busy, 0);
    end else begin
      check("load_busy", Load_Busy, 1);
      check("load_ready", Load_Ready, 1);
      for (int i = 0; i < cnt; i++) begin
        gaps = (gq.size() > 0) ? gq[i] : int'($urandom_range(3, 0));
        for (int g = 0; g < gaps; g++) begin
          Load_Valid = 1'b0;
          Load_Data  = DATA_W'($urandom);
          Load_Start = 1'($urandom_range(1, 0));
          Load_Base  = $urandom;
          Load_Count = CNT_W'($urandom_range(3, 0));
          step();
          Load_Start = 1'b0;
          check("gap_busy", Load_Busy, 1);
          check("gap_done", Load_Done, 0);
          check("gap_fetch_blocked", Fetch_Valid, 0);
        end
        Load_Valid = 1'b1;
        Load_Data  = wq[i];
        step();
        Load_Valid = 1'b0;
        model_write(base + 32'(i), wq[i]);
        ref_csum = ref_csum + wq[i];
        check("xfer_fetch_blocked", Fetch_Valid, 0);
        if (i < cnt - 1) check("mid_done", Load_Done, 0);
      end
      check("done_pulse", Load_Done, 1);
      check("done_busy", Load_Busy, 0);
      check("done_ready", Load_Ready, 0);
    end
    // Fetch during DONE must observe the final written word.
    Fetch_En   = (cnt > 0);
    PC_Address = base + 32'(cnt) - 32'd1;
    step();
    Fetch_En = 1'b0;
    check("done_one_cycle", Load_Done, 0);
    if (cnt > 0) begin
      check("done_fetch_valid", Fetch_Valid, 1);
      check("done_fetch_word", Instruction, wq[cnt-1]);
    end
`ifdef LOAD_CHECKSUM_EN
    check("checksum", Load_Checksum, ref_csum);
`endif
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    int a, an;
    Fetch_En   = 1'b1;
    PC_Address = pc;
    step();
    Fetch_En = 1'b0;
    a  = int'(pc & AMASK);
    an = int'((pc + 32'd1) & AMASK);
    check("fetch_valid", Fetch_Valid, 1);
    if (ref_mem.exists(a))  check("fetch_instr", Instruction, ref_mem[a]);
    if (ref_mem.exists(an)) check("fetch_next", Instruction_Next, ref_mem[an]);
  endtask

  initial begin
    // Reset and idle
    rst = 1'b1;
    step();
    step();
    check("rst_instr", Instruction, 0);
    check("rst_next", Instruction_Next, 0);
    check("rst_fvalid", Fetch_Valid, 0);
    check("rst_ready", Load_Ready, 0);
    check("rst_busy", Load_Busy, 0);
    check("rst_done", Load_Done, 0);
    rst = 1'b0;
    step();
    check("idle_fvalid", Fetch_Valid, 0);
    check("idle_busy", Load_Busy, 0);

    // Basic load, back-to-back words
    wq.delete(); gq.delete();
    wq.push_back(16'h1111); wq.push_back(16'h2222); wq.push_back(16'h3333);
    gq.push_back(0); gq.push_back(0); gq.push_back(0);
    do_load(32'h10, 1'b0);
    Fetch_En = 1'b1; PC_Address = 32'h11;
    step();
    Fetch_En = 1'b0;
    check("basic_fvalid", Fetch_Valid, 1);
    check("basic_instr", Instruction, 16'h2222);
    check("basic_next", Instruction_Next, 16'h3333);

    // Stalled stream (valid 1,0,0,1) with fetch held high throughout
    wq.delete(); gq.delete();
    wq.push_back(16'hC0DE); wq.push_back(16'hBEEF);
    gq.push_back(0); gq.push_back(2);
    do_load(32'h40, 1'b1);

    // Address wrap
    wq.delete(); gq.delete();
    wq.push_back(16'hAAAA); wq.push_back(16'hBBBB);
    gq.push_back(0); gq.push_back(0);
    do_load(32'h000F_FFFF, 1'b0);

    // Zero count: Load_Valid high must not write anything
    wq.delete(); gq.delete();
    Load_Valid = 1'b1; Load_Data = 16'hDEAD;
    do_load(32'h10, 1'b0);
    Load_Valid = 1'b0;

    tbl[0] = '{1'b1, 32'h0000_0010, 1'b1, 16'h1111, 16'h2222};
    tbl[1] = '{1'b0, 32'h000F_FFFF, 1'b0, 16'h1111, 16'h2222};
    tbl[2] = '{1'b1, 32'h000F_FFFF, 1'b1, 16'hAAAA, 16'hBBBB};
    tbl[3] = '{1'b1, 32'h0010_0011, 1'b1, 16'h2222, 16'h3333};
    tbl[4] = '{1'b1, 32'h7FFF_FFFF, 1'b1, 16'hAAAA, 16'hBBBB};
    tbl[5] = '{1'b1, 32'hABC0_0040, 1'b1, 16'hC0DE, 16'hBEEF};
    tbl[6] = '{1'b0, 32'h0000_0011, 1'b0, 16'hC0DE, 16'hBEEF};
    for (int i = 0; i < 7; i++) begin
      Fetch_En   = tbl[i].en;
      PC_Address = tbl[i].pc;
      step();
      check($sformatf("tbl%0d_valid", i), Fetch_Valid, tbl[i].valid);
      check($sformatf("tbl%0d_instr", i), Instruction, tbl[i].instr);
      check($sformatf("tbl%0d_next", i), Instruction_Next, tbl[i].nxt);
    end
    Fetch_En = 1'b0;

    // Reset abort after one of four words
    Load_Base = 32'h200; Load_Count = CNT_W'(4); Load_Start = 1'b1;
    step();
    Load_Start = 1'b0;
    Load_Valid = 1'b1; Load_Data = 16'h5A5A;
    step();
    model_write(32'h200, 16'h5A5A);
    Load_Data = 16'h6666;
    rst = 1'b1;
    step();
    rst = 1'b0;
    Load_Valid = 1'b0;
    check("abort_busy", Load_Busy, 0);
    check("abort_ready", Load_Ready, 0);
    check("abort_done", Load_Done, 0);
    check("abort_instr", Instruction, 0);
    step();
    check("abort_no_done1", Load_Done, 0);
    step();
    check("abort_no_done2", Load_Done, 0);
    do_fetch(32'h200);

`ifdef LOAD_CHECKSUM_EN
    wq.delete(); gq.delete();
    wq.push_back(16'hFFFF); wq.push_back(16'h0002);
    gq.push_back(0); gq.push_back(0);
    do_load(32'h300, 1'b0);
    check("checksum_wrap", Load_Checksum, 16'h0001);
`endif

    // Randomised loads and fetches against the model
    for (int r = 0; r < 20; r++) begin
      logic [31:0] base;
      wq.delete(); gq.delete();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) wq.push_back(DATA_W'($urandom));
      base = ($urandom_range(1, 0) == 1) ? 32'($urandom_range(32'hFFFFF, 32'hFFFF8)) : $urandom;
      do_load(base, 1'($urandom_range(1, 0)));
    end
    for (int r = 0; r < 40; r++) begin
      logic [31:0] pc;
      pc = 32'(written[$urandom_range(written.size() - 1, 0)]) | ($urandom & 32'hFFF0_0000);
      do_fetch(pc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
